// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// PIPE_LAT must track the operand-to-accumulator latency of the attached MAC.
package mac_seq_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned LEN_W_DEF  = 16;
  localparam int unsigned PIPE_LAT   = 4;
  localparam int unsigned DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Job, operand, MAC and result signals of the dot-product sequencer.
// slave is the sequencer side; master is the surrounding fetch/MAC/consumer side.
interface mac_seq_ctrl_if #(
  parameter int unsigned DATA_W = mac_seq_ctrl_pkg::DATA_W_DEF,
  parameter int unsigned LEN_W  = mac_seq_ctrl_pkg::LEN_W_DEF
) ();

  logic              start;
  logic              abort;
  logic [LEN_W-1:0]  len;
  logic              busy;

  logic              op_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_ready;

  logic [DATA_W-1:0] mac_a;
  logic [DATA_W-1:0] mac_b;
  logic              mac_en;
  logic              mac_rst;
  logic [DATA_W-1:0] mac_acc;

  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (
    output start, abort, len, op_valid, op_a, op_b, mac_acc, res_ready,
    input  busy, op_ready, mac_a, mac_b, mac_en, mac_rst, res_valid, res_data
  );

  modport slave (
    input  start, abort, len, op_valid, op_a, op_b, mac_acc, res_ready,
    output busy, op_ready, mac_a, mac_b, mac_en, mac_rst, res_valid, res_data
  );

endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequences one pipelined MAC through a dot product of programmable length,
// zero-filling idle cycles and returning the accumulator after the pipeline drains.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mac_seq_ctrl_if.slave bus
);

  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_LAT - 1);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic [DRAIN_W-1:0] dcnt_q, dcnt_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              hs_c;

  assign hs_c    = (state_q == RUN) && bus.op_valid;
  assign cnt_inc = cnt_q + LEN_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Job length, operand/drain counters and captured result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q  <= '0;
      cnt_q  <= '0;
      dcnt_q <= '0;
      res_q  <= '0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      dcnt_q <= dcnt_d;
      res_q  <= res_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          len_d   = bus.len;
          cnt_d   = '0;
          dcnt_d  = '0;
          state_d = (bus.len == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.op_valid) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            dcnt_d  = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DRAIN_W'(1);
          // Last operand has just reached the accumulator
          if (dcnt_q == DRAIN_LAST) begin
            res_d   = bus.mac_acc;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control outputs decode the state register only
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_ready  = (state_q == RUN);
  assign bus.mac_en    = (state_q != IDLE);
  assign bus.mac_rst   = (state_q == IDLE);
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = res_q;

  // The MAC re-adds its held stage-1 product, so every non-handshake cycle feeds zeros
  assign bus.mac_a = (hs_c && !bus.abort) ? bus.op_a : '0;
  assign bus.mac_b = (hs_c && !bus.abort) ? bus.op_b : '0;

  res_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (bus.res_valid && !bus.res_ready) |=> (bus.res_valid && $stable(bus.res_data)));

  ready_busy_a: assert property (@(posedge clk) disable iff (!rst)
    bus.op_ready |-> bus.busy);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl driving a behavioural 3-stage MAC plus output register.
module tb_mac_seq_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned LW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DATA_W(DW), .LEN_W(LW)) ifc ();

  mac_seq_ctrl #(.DATA_W(DW), .LEN_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Behavioural MAC: operand in cycle t appears on mac_acc in cycle t+4
  logic [DW-1:0] p1, p2, p3, acc;
  always @(posedge clk) begin
    if (ifc.mac_rst) begin
      p1 <= '0; p2 <= '0; p3 <= '0; acc <= '0;
    end else begin
      if (ifc.mac_en) p1 <= DW'($signed(ifc.mac_a) * $signed(ifc.mac_b));
      p2  <= p1;
      p3  <= p2;
      acc <= acc + p3;
    end
  end
  assign ifc.mac_acc = acc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  int            n_rise = 0;
  int            n_take = 0;
  logic          rv_prev = 1'b0;
  logic [DW-1:0] rd_prev = '0;

  // Monitor: pop and compare on each rising res_valid; check stability while held
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      rv_prev = 1'b0;
    end else begin
      if (ifc.res_valid && !rv_prev) begin
        n_rise++;
        if (sb.size() == 0) begin
          chk("unexpected_res_valid", 64'(ifc.res_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("res_data", 64'(ifc.res_data), 64'(e.data));
          chk("res_valid_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (ifc.res_valid) begin
        chk("res_data_stable", 64'(ifc.res_data), 64'(rd_prev));
      end
      if (ifc.res_valid && ifc.res_ready) n_take++;
      rv_prev = ifc.res_valid;
      rd_prev = ifc.res_data;
    end
  end

  logic [DW-1:0] pa[$];
  logic [DW-1:0] pb[$];

  task automatic add_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    pa.push_back(a);
    pb.push_back(b);
  endtask

  task automatic clear_pairs();
    pa.delete();
    pb.delete();
  endtask

  task automatic check_reset_values();
    chk("rst_busy",      64'(ifc.busy),      64'd0);
    chk("rst_op_ready",  64'(ifc.op_ready),  64'd0);
    chk("rst_mac_a",     64'(ifc.mac_a),     64'd0);
    chk("rst_mac_b",     64'(ifc.mac_b),     64'd0);
    chk("rst_mac_en",    64'(ifc.mac_en),    64'd0);
    chk("rst_mac_rst",   64'(ifc.mac_rst),   64'd1);
    chk("rst_res_valid", 64'(ifc.res_valid), 64'd0);
    chk("rst_res_data",  64'(ifc.res_data),  64'd0);
  endtask

  // Runs one job from an IDLE cycle (entered at posedge+1).
  // mode: 0 op_valid always high, 1 alternate cycles, 2 random.
  task automatic run_job(input int n, input int mode, input int abort_at,
                         input bit hold, input bit rst_drain);
    int            s, hs, last, wd, g, rise0, take0;
    bit            v, aborted;
    logic [DW-1:0] sum;
    longint        pr;
    rise0 = n_rise;
    take0 = n_take;
    ifc.start = 1'b1;
    ifc.len   = LW'(n);
    s = cyc;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    hs = 0; wd = 0; last = s; sum = '0; aborted = 1'b0;
    while (hs < n && !aborted && wd < 400) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (wd % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      wd++;
      if (abort_at >= 0 && hs == abort_at) begin
        ifc.abort    = 1'b1;
        ifc.op_valid = 1'b1;
        ifc.op_a     = pa[hs];
        ifc.op_b     = pb[hs];
        aborted      = 1'b1;
        @(negedge clk);
        chk("op_ready_run", 64'(ifc.op_ready), 64'd1);
        @(posedge clk); #1;
        ifc.abort    = 1'b0;
        ifc.op_valid = 1'b0;
      end else begin
        ifc.op_valid = v;
        ifc.op_a     = v ? pa[hs] : DW'($urandom);
        ifc.op_b     = v ? pb[hs] : DW'($urandom);
        @(negedge clk);
        chk("op_ready_run", 64'(ifc.op_ready), 64'd1);
        chk("mac_a_run", 64'(ifc.mac_a), v ? 64'(pa[hs]) : 64'd0);
        chk("mac_b_run", 64'(ifc.mac_b), v ? 64'(pb[hs]) : 64'd0);
        if (v) begin
          pr   = longint'($signed(pa[hs])) * longint'($signed(pb[hs]));
          sum  = sum + pr[DW-1:0];
          hs++;
          last = cyc;
        end
        @(posedge clk); #1;
      end
    end
    ifc.op_valid = 1'b0;
    if (aborted) begin
      repeat (8) begin
        @(negedge clk);
        chk("busy_after_abort", 64'(ifc.busy), 64'd0);
        chk("op_ready_after_abort", 64'(ifc.op_ready), 64'd0);
        @(posedge clk); #1;
      end
      return;
    end
    if (rst_drain) begin
      #1 rst = 1'b0;
      #1 check_reset_values();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      return;
    end
    sb.push_back('{data: sum, due: (n == 0) ? s + 5 : last + 5});
    g = 0;
    while (n_rise == rise0 && g < 20) begin
      @(negedge clk);
      chk("op_ready_drain", 64'(ifc.op_ready), 64'd0);
      chk("mac_a_drain", 64'(ifc.mac_a), 64'd0);
      chk("busy_drain", 64'(ifc.busy), 64'd1);
      @(posedge clk); #1;
      g++;
    end
    if (n_rise == rise0) chk("result_timeout", 64'(n_rise), 64'(rise0 + 1));
    if (hold) begin
      repeat (10) begin
        ifc.start = 1'b1;
        ifc.len   = LW'(1);
        @(negedge clk);
        chk("busy_done_hold", 64'(ifc.busy), 64'd1);
        chk("res_valid_hold", 64'(ifc.res_valid), 64'd1);
        @(posedge clk); #1;
      end
      ifc.start = 1'b0;
    end
    ifc.res_ready = 1'b1;
    g = 0;
    while (n_take == take0 && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    if (n_take == take0) chk("take_timeout", 64'(n_take), 64'(take0 + 1));
    @(negedge clk);
    chk("busy_idle", 64'(ifc.busy), 64'd0);
    chk("mac_rst_idle", 64'(ifc.mac_rst), 64'd1);
    chk("res_valid_idle", 64'(ifc.res_valid), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.len       = '0;
    ifc.op_valid  = 1'b0;
    ifc.op_a      = '0;
    ifc.op_b      = '0;
    ifc.res_ready = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_values();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // Basic dot product, continuous operands: 6 + 20 - 7 = 19
    clear_pairs();
    add_pair(32'd2, 32'd3);
    add_pair(32'd4, 32'd5);
    add_pair(32'hFFFF_FFFF, 32'd7);
    run_job(3, 0, -1, 1'b0, 1'b0);

    // Gapped operands must not re-accumulate stale products
    clear_pairs();
    repeat (4) add_pair(32'd1, 32'd1);
    run_job(4, 1, -1, 1'b0, 1'b0);

    // Zero-length job
    clear_pairs();
    run_job(0, 0, -1, 1'b0, 1'b0);

    // Result held in DONE with consumer stalled, then a fresh job
    clear_pairs();
    add_pair(32'd10, 32'd10);
    add_pair(32'hFFFF_FFFD, 32'd4);
    ifc.res_ready = 1'b0;
    run_job(2, 0, -1, 1'b1, 1'b0);
    clear_pairs();
    add_pair(32'd3, 32'd3);
    run_job(1, 0, -1, 1'b0, 1'b0);

    // Abort after two handshakes, then a fresh job: 5 * -2 = -10
    clear_pairs();
    repeat (5) add_pair(DW'($urandom), DW'($urandom));
    run_job(5, 0, 2, 1'b0, 1'b0);
    clear_pairs();
    add_pair(32'd5, 32'hFFFF_FFFE);
    run_job(1, 0, -1, 1'b0, 1'b0);

    // start together with abort in IDLE is refused
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    ifc.len   = LW'(3);
    @(posedge clk); #1;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 64'(ifc.busy), 64'd0);
    @(posedge clk); #1;

    // Reset mid-drain, then 6*7 + 1*1 = 43
    clear_pairs();
    repeat (3) add_pair(32'd9, 32'd9);
    run_job(3, 0, -1, 1'b0, 1'b1);
    @(posedge clk); #1;
    clear_pairs();
    add_pair(32'd6, 32'd7);
    add_pair(32'd1, 32'd1);
    run_job(2, 0, -1, 1'b0, 1'b0);

    // Random jobs with random operand gaps and full-range signed operands
    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 8));
      clear_pairs();
      for (int k = 0; k < n; k++) add_pair(DW'($urandom), DW'($urandom));
      run_job(n, 2, -1, 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
